// File: rtl/mux2x1_pkg.sv
// Shared definitions for the ping-pong loader that feeds mux2x1_Ninput.
// Holds the occupancy state encoding and the default word width, so the
// loader and the downstream mux agree on both.
package mux2x1_pkg;

  // Occupancy states; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  // Default word width, matched to the downstream mux.
  localparam int DEFAULT_SIZE = 4;

endpackage

// File: rtl/pingpong_ctrl.sv
// Occupancy FSM and bank pointers for the two-bank ping-pong loader.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   flush           - synchronous clear of occupancy and pointers
//   wr_valid        - producer offers a word
//   rd_ack          - consumer retires the presented word
//   wr_en0, wr_en1  - load strobes for bank 0 / bank 1 this cycle
//   rd_ptr          - bank holding the oldest word (mux select)
//   wr_ready        - a bank is free (decode of state only)
//   rd_valid        - the selected bank holds a valid word
//   count           - occupancy 0..2, equal to the state encoding
module pingpong_ctrl
  import mux2x1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       wr_valid,
  input  logic       rd_ack,
  output logic       wr_en0,
  output logic       wr_en1,
  output logic       rd_ptr,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic [1:0] count
);

  occ_state_t r_state;
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic       w_wrFire;
  logic       w_rdFire;

  // A write or read only takes effect when the handshake completes and no
  // flush is present; flush wins over both, so the write is dropped.
  assign w_wrFire = wr_valid && (r_state != ST_FULL) && !flush;
  assign w_rdFire = rd_ack && (r_state != ST_EMPTY) && !flush;

  assign wr_en0   = w_wrFire && !r_wrPtr;
  assign wr_en1   = w_wrFire &&  r_wrPtr;
  assign rd_ptr   = r_rdPtr;
  assign wr_ready = (r_state != ST_FULL);
  assign rd_valid = (r_state != ST_EMPTY);
  assign count    = r_state;

  // Occupancy FSM plus pointer toggling. A simultaneous write and read in
  // ONE keeps the occupancy but advances both pointers; FULL can never see
  // a write because wr_ready is low there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_wrFire) r_wrPtr <= ~r_wrPtr;
      if (w_rdFire) r_rdPtr <= ~r_rdPtr;
      case (r_state)
        ST_EMPTY: if (w_wrFire) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_wrFire && !w_rdFire)      r_state <= ST_FULL;
          else if (w_rdFire && !w_wrFire) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_rdFire) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mux2x1_pingpong_loader.sv
// Two-bank ping-pong loader placed directly upstream of mux2x1_Ninput.
// Words arrive over a valid/ready handshake and are stored alternately in
// bank 0 and bank 1; the select always points at the oldest unconsumed word,
// so the mux plus this block behave as a 2-deep FIFO.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous discard of both banks (data kept)
//   wr_valid, wr_data    - write side; accepted when wr_ready is high
//   wr_ready             - a bank is free
//   rd_ack               - consumer retires the presented word
//   rd_valid             - selected bank holds a valid word
//   mux2x1_i0/i1         - bank contents to mux inputs
//   mux2x1_sel           - read pointer to mux select
//   count                - occupancy 0..2
module mux2x1_pingpong_loader
  import mux2x1_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            wr_valid,
  input  logic [SIZE-1:0] wr_data,
  output logic            wr_ready,
  input  logic            rd_ack,
  output logic            rd_valid,
  output logic [SIZE-1:0] mux2x1_i0,
  output logic [SIZE-1:0] mux2x1_i1,
  output logic            mux2x1_sel,
  output logic [1:0]      count
);

  logic            w_wrEn0;
  logic            w_wrEn1;
  logic [SIZE-1:0] r_bank0;
  logic [SIZE-1:0] r_bank1;

  pingpong_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_valid (wr_valid),
    .rd_ack   (rd_ack),
    .wr_en0   (w_wrEn0),
    .wr_en1   (w_wrEn1),
    .rd_ptr   (mux2x1_sel),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .count    (count)
  );

  // Bank storage. Reads and flushes never clear data; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else begin
      if (w_wrEn0) r_bank0 <= wr_data;
      if (w_wrEn1) r_bank1 <= wr_data;
    end
  end

  assign mux2x1_i0 = r_bank0;
  assign mux2x1_i1 = r_bank1;

endmodule

// File: tb/tb_mux2x1_pingpong_loader.sv
// Self-checking bench for mux2x1_pingpong_loader: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a queue-based FIFO model of the loader.
module tb_mux2x1_pingpong_loader;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            wr_valid = 1'b0;
  logic [SIZE-1:0] wr_data = '0;
  logic            rd_ack = 1'b0;
  logic            wr_ready;
  logic            rd_valid;
  logic [SIZE-1:0] mux2x1_i0;
  logic [SIZE-1:0] mux2x1_i1;
  logic            mux2x1_sel;
  logic [1:0]      count;
  logic [SIZE-1:0] muxOut;

  int nCompared = 0;
  int nMismatched = 0;

  // Behavioural model: a 2-deep FIFO, plus bank images addressed by how many
  // words were written / read since the last clear.
  logic [SIZE-1:0] modelQ[$];
  logic [SIZE-1:0] modelBank[2];
  int              modelWrN = 0;
  int              modelRdN = 0;

  mux2x1_pingpong_loader #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .mux2x1_i0  (mux2x1_i0),
    .mux2x1_i1  (mux2x1_i1),
    .mux2x1_sel (mux2x1_sel),
    .count      (count)
  );

  always #5 clk = ~clk;

  // What mux2x1_Ninput would present downstream.
  assign muxOut = mux2x1_sel ? mux2x1_i1 : mux2x1_i0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each clock edge from the inputs presented before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
      modelBank[0] = '0;
      modelBank[1] = '0;
      modelWrN = 0;
      modelRdN = 0;
    end else if (flush) begin
      modelQ.delete();
      modelWrN = 0;
      modelRdN = 0;
    end else begin
      automatic bit doRead  = rd_ack && (modelQ.size() > 0);
      automatic bit doWrite = wr_valid && (modelQ.size() < 2);
      if (doRead) begin
        void'(modelQ.pop_front());
        modelRdN++;
      end
      if (doWrite) begin
        modelBank[modelWrN % 2] = wr_data;
        modelWrN++;
        modelQ.push_back(wr_data);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("count",    int'(count),      modelQ.size());
      checkOutput("rd_valid", int'(rd_valid),   int'(modelQ.size() != 0));
      checkOutput("wr_ready", int'(wr_ready),   int'(modelQ.size() != 2));
      checkOutput("sel",      int'(mux2x1_sel), modelRdN % 2);
      checkOutput("i0",       int'(mux2x1_i0),  int'(modelBank[0]));
      checkOutput("i1",       int'(mux2x1_i1),  int'(modelBank[1]));
      if (modelQ.size() != 0) checkOutput("muxOut", int'(muxOut), int'(modelQ[0]));
    end
  end

  // Present one cycle of inputs (called at a negedge), let the edge take
  // them, and return at the following negedge with inputs idle.
  task automatic applyStimulus(input logic wv, input logic [SIZE-1:0] wd,
                               input logic ack, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ack   = ack;
    flush    = fl;
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ack   = 1'b0;
    flush    = 1'b0;
  endtask

  logic [SIZE-1:0] streamWords[8];

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle values.
    checkOutput("rst count",    int'(count), 0);
    checkOutput("rst wr_ready", int'(wr_ready), 1);
    checkOutput("rst rd_valid", int'(rd_valid), 0);
    checkOutput("rst sel",      int'(mux2x1_sel), 0);
    checkOutput("rst i0",       int'(mux2x1_i0), 0);
    checkOutput("rst i1",       int'(mux2x1_i1), 0);

    // Fill to FULL, then an extra write that must be refused.
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    checkOutput("w1 count",  int'(count), 1);
    checkOutput("w1 muxOut", int'(muxOut), 'hA);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    checkOutput("w2 count",    int'(count), 2);
    checkOutput("w2 wr_ready", int'(wr_ready), 0);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    checkOutput("w3 i0",    int'(mux2x1_i0), 'hA);
    checkOutput("w3 count", int'(count), 2);

    // Drain from FULL.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("r1 muxOut", int'(muxOut), 'h5);
    checkOutput("r1 sel",    int'(mux2x1_sel), 1);
    checkOutput("r1 count",  int'(count), 1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("r2 count",    int'(count), 0);
    checkOutput("r2 rd_valid", int'(rd_valid), 0);

    // ONE holding 3, then simultaneous write 7 and ack.
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    checkOutput("one muxOut", int'(muxOut), 'h3);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
    checkOutput("wr+ack count",  int'(count), 1);
    checkOutput("wr+ack muxOut", int'(muxOut), 'h7);

    // Back-to-back stream: each new word visible one cycle after it is sent.
    for (int i = 0; i < 8; i++) streamWords[i] = SIZE'((i * 5 + 2) % 16);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, streamWords[i], 1'b1, 1'b0);
      checkOutput("stream muxOut", int'(muxOut), int'(streamWords[i]));
      checkOutput("stream count",  int'(count), 1);
    end

    // Flush, then ack while EMPTY has no effect.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("empty-ack sel",   int'(mux2x1_sel), 0);
    checkOutput("empty-ack count", int'(count), 0);

    // Flush while FULL with a concurrent write of C: write is dropped.
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b1);
    checkOutput("flush count", int'(count), 0);
    checkOutput("flush sel",   int'(mux2x1_sel), 0);
    checkOutput("flush i0",    int'(mux2x1_i0), 'h1);
    checkOutput("flush i1",    int'(mux2x1_i1), 'h2);
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    checkOutput("post-flush i0", int'(mux2x1_i0), 'h9);

    // Asynchronous reset while FULL.
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async count", int'(count), 0);
    checkOutput("async sel",   int'(mux2x1_sel), 0);
    checkOutput("async i0",    int'(mux2x1_i0), 0);
    checkOutput("async ready", int'(wr_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic, checked each cycle by the model compare process.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(1)), SIZE'($urandom_range(15)),
                    logic'($urandom_range(1)), logic'($urandom_range(15) == 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
